// File: rtl/branch_release_ctrl_if.sv
// rtl/branch_release_ctrl_if.sv - ID/EX-side and PC/IF-side signal bundle for branch_release_ctrl
//
// Purpose: groups every signal exchanged between the branch release
// controller and the surrounding pipeline.
//   master : pipeline side; drives ID/EX inputs and reads the control outputs
//   slave  : branch_release_ctrl side
// Signals:
//   id_valid, id_op[5:0]                  instruction currently in ID
//   ex_resolved, ex_taken, ex_target[31:0] branch outcome reported by EX
//   stall_n, flush_f, pc_sel              PC / IF-ID write-enable and bubble controls
//   pc_redirect[31:0]                     latched branch target
//   busy, timeout_err                     status
//   stat_stall_cycles, stat_taken         statistics (STAT_W wide)
interface branch_release_ctrl_if #(
    parameter int STAT_W = 16
);
    logic              id_valid;
    logic [5:0]        id_op;
    logic              ex_resolved;
    logic              ex_taken;
    logic [31:0]       ex_target;
    logic              stall_n;
    logic              flush_f;
    logic              pc_sel;
    logic [31:0]       pc_redirect;
    logic              busy;
    logic              timeout_err;
    logic [STAT_W-1:0] stat_stall_cycles;
    logic [STAT_W-1:0] stat_taken;

    modport master (
        output id_valid, id_op, ex_resolved, ex_taken, ex_target,
        input  stall_n, flush_f, pc_sel, pc_redirect, busy, timeout_err,
        input  stat_stall_cycles, stat_taken
    );

    modport slave (
        input  id_valid, id_op, ex_resolved, ex_taken, ex_target,
        output stall_n, flush_f, pc_sel, pc_redirect, busy, timeout_err,
        output stat_stall_cycles, stat_taken
    );
endinterface

// File: rtl/branch_release_ctrl.sv
// rtl/branch_release_ctrl.sv - control-hazard resolver holding fetch until EX resolves a branch
//
// Purpose: detects beq/bne/j in ID, freezes PC and IF/ID while bubbling,
// waits for EX to resolve, then redirects the PC (taken/jump) or releases
// the stall (not taken). A branch that never resolves is force-released
// after WAIT_LIMIT cycles and flags the sticky timeout_err.
// Parameters:
//   WAIT_LIMIT  WAIT cycles without ex_resolved before a forced release
//   CNT_W       wait counter width, 2**CNT_W > WAIT_LIMIT
//   STAT_W      statistics counter width (must match the interface)
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   bus         branch_release_ctrl_if.slave, see the interface file
// Optional feature macro: BRANCH_RELEASE_STATS_EN
//   defined   : stat_stall_cycles / stat_taken are saturating counters
//   undefined : both stat outputs are tied to zero
module branch_release_ctrl #(
    parameter int WAIT_LIMIT = 4,
    parameter int CNT_W      = 3,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_release_ctrl_if.slave  bus
);

    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [5:0]       OP_BNE   = 6'b000101;
    localparam logic [5:0]       OP_J     = 6'b000010;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         stall_n_q, stall_n_d;
    logic         flush_f_q, flush_f_d;
    logic         pc_sel_q, pc_sel_d;
    logic [31:0]  pc_redirect_q, pc_redirect_d;
    logic         busy_q, busy_d;
    logic         timeout_err_q, timeout_err_d;
    logic         detect;

    assign detect = bus.id_valid &&
                    ((bus.id_op == OP_BEQ) || (bus.id_op == OP_BNE) || (bus.id_op == OP_J));

    // Outputs are computed for the next state and registered, so every
    // output reflects the state entered on the same edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_n_d     = 1'b1;
        flush_f_d     = 1'b0;
        pc_sel_d      = 1'b0;
        pc_redirect_d = pc_redirect_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    stall_n_d = 1'b0;
                    flush_f_d = 1'b1;
                end
            end

            ST_WAIT: begin
                // ID is frozen here, so id_op is not looked at.
                // A resolve on the limit cycle wins over the timeout.
                if (bus.ex_resolved && bus.ex_taken) begin
                    state_d       = ST_REDIRECT;
                    pc_redirect_d = bus.ex_target;
                    pc_sel_d      = 1'b1;
                    flush_f_d     = 1'b1;
                end else if (bus.ex_resolved) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == LIMIT_M1) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    stall_n_d = 1'b0;
                    flush_f_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_REDIRECT: begin
                // The ID instruction is being flushed, so no detect here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            stall_n_q     <= 1'b1;
            flush_f_q     <= 1'b0;
            pc_sel_q      <= 1'b0;
            pc_redirect_q <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_n_q     <= stall_n_d;
            flush_f_q     <= flush_f_d;
            pc_sel_q      <= pc_sel_d;
            pc_redirect_q <= pc_redirect_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.stall_n     = stall_n_q;
    assign bus.flush_f     = flush_f_q;
    assign bus.pc_sel      = pc_sel_q;
    assign bus.pc_redirect = pc_redirect_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;

`ifdef BRANCH_RELEASE_STATS_EN
    logic [STAT_W-1:0] stat_stall_q;
    logic [STAT_W-1:0] stat_taken_q;
    logic              enter_redirect;

    // REDIRECT lasts one cycle and is only reachable from WAIT, so a
    // next-state of REDIRECT is exactly one entry.
    assign enter_redirect = (state_d == ST_REDIRECT);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall_q <= '0;
            stat_taken_q <= '0;
        end else begin
            if (!stall_n_q && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 1'b1;
            end
            if (enter_redirect && (stat_taken_q != '1)) begin
                stat_taken_q <= stat_taken_q + 1'b1;
            end
        end
    end

    assign bus.stat_stall_cycles = stat_stall_q;
    assign bus.stat_taken        = stat_taken_q;
`else
    assign bus.stat_stall_cycles = {STAT_W{1'b0}};
    assign bus.stat_taken        = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_release_ctrl.sv
// tb/tb_branch_release_ctrl.sv - self-checking bench for branch_release_ctrl
module tb_branch_release_ctrl;

    localparam int         WAIT_LIMIT = 4;
    localparam int         CNT_W      = 3;
    localparam int         STAT_W     = 16;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_release_ctrl_if #(.STAT_W(STAT_W)) bus ();

    branch_release_ctrl #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W),
        .STAT_W     (STAT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic        exp_timeout;
    logic [31:0] exp_redirect;
    int          exp_stall_cnt;
    int          exp_taken_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_timeout   = 1'b0;
        exp_redirect  = 32'h0;
        exp_stall_cnt = 0;
        exp_taken_cnt = 0;
    endtask

    // One call per cycle: checks the whole output set against the
    // per-transaction expectation and advances the statistics model.
    task automatic check_outputs(input string ph, input logic s, input logic f,
                                 input logic p, input logic b);
        if (p) exp_taken_cnt++;
        chk({ph, ".stall_n"},     {31'b0, bus.stall_n},     {31'b0, s});
        chk({ph, ".flush_f"},     {31'b0, bus.flush_f},     {31'b0, f});
        chk({ph, ".pc_sel"},      {31'b0, bus.pc_sel},      {31'b0, p});
        chk({ph, ".busy"},        {31'b0, bus.busy},        {31'b0, b});
        chk({ph, ".pc_redirect"}, bus.pc_redirect,          exp_redirect);
        chk({ph, ".timeout_err"}, {31'b0, bus.timeout_err}, {31'b0, exp_timeout});
`ifdef BRANCH_RELEASE_STATS_EN
        chk({ph, ".stat_stall"},  32'(bus.stat_stall_cycles), 32'(exp_stall_cnt));
        chk({ph, ".stat_taken"},  32'(bus.stat_taken),        32'(exp_taken_cnt));
`else
        chk({ph, ".stat_stall"},  32'(bus.stat_stall_cycles), 32'h0);
        chk({ph, ".stat_taken"},  32'(bus.stat_taken),        32'h0);
`endif
        if (!s) exp_stall_cnt++;
    endtask

    function automatic logic [5:0] rand_noncontrol();
        logic [5:0] o;
        do o = 6'($urandom); while (o == OP_BEQ || o == OP_BNE || o == OP_J);
        return o;
    endfunction

    function automatic logic [5:0] rand_control();
        case ($urandom_range(0, 2))
            0:       return OP_BEQ;
            1:       return OP_BNE;
            default: return OP_J;
        endcase
    endfunction

    // Reset with a live detect and resolve on the inputs; both must be ignored.
    task automatic do_reset(input string tag);
        reset           = 1'b1;
        bus.id_valid    = 1'b1;
        bus.id_op       = OP_BEQ;
        bus.ex_resolved = 1'b1;
        bus.ex_taken    = 1'b1;
        bus.ex_target   = $urandom;
        tick();
        model_reset();
        check_outputs({tag, ".reset"}, 1'b1, 1'b0, 1'b0, 1'b0);
        reset           = 1'b0;
        bus.id_valid    = 1'b0;
        bus.ex_resolved = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        check_outputs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_valid    = 1'($urandom);
        bus.id_op       = bus.id_valid ? rand_noncontrol() : rand_control();
        bus.ex_resolved = 1'($urandom);
        bus.ex_taken    = 1'($urandom);
        bus.ex_target   = $urandom;
        tick();
    endtask

    // One branch transaction: resolve on WAIT cycle d (d > WAIT_LIMIT means
    // never). Expected waveform: d (or WAIT_LIMIT) stall cycles, then one
    // redirect cycle if taken. rst_cycle numbers the transaction's cycles
    // (WAIT 1..n, REDIRECT n+1) and asserts reset there; 0 means none.
    task automatic run_branch(input logic [5:0] op, input int d, input logic taken,
                              input logic [31:0] target, input int rst_cycle,
                              input string tag);
        bit resolved = 1'b0;
        check_outputs({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_valid    = 1'b1;
        bus.id_op       = op;
        bus.ex_resolved = 1'($urandom);
        bus.ex_taken    = 1'($urandom);
        bus.ex_target   = $urandom;
        tick();
        for (int k = 1; k <= WAIT_LIMIT; k++) begin
            check_outputs({tag, ".wait"}, 1'b0, 1'b1, 1'b0, 1'b1);
            if (k == rst_cycle) begin
                do_reset(tag);
                return;
            end
            bus.id_valid    = 1'($urandom);
            bus.id_op       = 6'($urandom);
            bus.ex_resolved = (k == d);
            bus.ex_taken    = (k == d) ? taken : 1'($urandom);
            bus.ex_target   = (k == d) ? target : $urandom;
            tick();
            if (k == d) begin
                resolved = 1'b1;
                break;
            end
        end
        if (resolved && taken) begin
            exp_redirect = target;
            check_outputs({tag, ".redirect"}, 1'b1, 1'b1, 1'b1, 1'b1);
            if (rst_cycle == d + 1) begin
                do_reset(tag);
                return;
            end
            bus.id_valid    = 1'b1;
            bus.id_op       = rand_control();
            bus.ex_resolved = 1'($urandom);
            bus.ex_taken    = 1'($urandom);
            bus.ex_target   = $urandom;
            tick();
        end else if (!resolved) begin
            exp_timeout = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        reset           = 1'b1;
        bus.id_valid    = 1'b1;
        bus.id_op       = OP_BEQ;
        bus.ex_resolved = 1'b0;
        bus.ex_taken    = 1'b0;
        bus.ex_target   = 32'h0;

        tick();
        check_outputs("rst1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset        = 1'b0;
        check_outputs("rst2", 1'b1, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
        tick();

        run_branch(OP_BEQ, 2, 1'b1, 32'h0000_0040, 0, "beq_taken");
        run_branch(OP_BNE, 1, 1'b0, $urandom, 0, "bne_nt");
        run_branch(OP_J, 99, 1'b1, $urandom, 0, "j_timeout");
        idle_cycle("timeout_hold1");
        idle_cycle("timeout_hold2");
        chk("timeout_sticky", {31'b0, bus.timeout_err}, 32'h1);

        do_reset("clr_timeout");
        run_branch(OP_J, WAIT_LIMIT, 1'b1, 32'hdead_beef, 0, "j_last_cycle");
        chk("resolve_beats_limit", {31'b0, bus.timeout_err}, 32'h0);

        run_branch(OP_BEQ, 1, 1'b1, 32'h0000_0100, 2, "rst_redirect");
        chk("rst_redirect_pc_sel", {31'b0, bus.pc_sel}, 32'h0);
        run_branch(OP_BNE, 3, 1'b0, $urandom, 2, "rst_wait");

        run_branch(OP_BEQ, 2, 1'b1, 32'h0000_1000, 0, "stat_a");
        run_branch(OP_BNE, 2, 1'b1, 32'h0000_2000, 0, "stat_b");
`ifdef BRANCH_RELEASE_STATS_EN
        chk("stat_taken_two", 32'(bus.stat_taken), 32'd2);
        chk("stat_stall_four", 32'(bus.stat_stall_cycles), 32'd4);
`else
        chk("stat_taken_off", 32'(bus.stat_taken), 32'd0);
        chk("stat_stall_off", 32'(bus.stat_stall_cycles), 32'd0);
`endif

        for (int t = 0; t < 150; t++) begin
            logic [5:0] op;
            logic       tk;
            int         rc;
            op = rand_control();
            tk = (op == OP_J) ? 1'b1 : 1'($urandom);
            rc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_branch(op, int'($urandom_range(1, 6)), tk, $urandom, rc, "rand");
            repeat ($urandom_range(0, 2)) idle_cycle("rand_gap");
        end

        idle_cycle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
